// File: rtl/rva_router_n_pkg.sv
// Shared constants, default widths and start/done FSM states for rva_router_n.
package rva_router_n_pkg;

  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_MSG_W   = 169;
  localparam int DEF_RSP_W   = 128;
  localparam int DEF_SEL_LSB = 20;
  localparam int DEF_SEL_MSB = 23;

  // Fill bit replicated across the response width for an out-of-range read
  localparam logic ERR_RSP_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BCAST = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } start_st_e;

endpackage

// File: rtl/rva_router_n_skid.sv
// 1-entry val/rdy buffer; pass_en gates refilling in the cycle the entry drains.
module rva_router_n_skid #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_msg,
  input  logic         in_val,
  output logic         in_rdy,
  output logic [W-1:0] out_msg,
  output logic         out_val,
  input  logic         out_rdy,
  input  logic         pass_en
);

  logic         vld;
  logic [W-1:0] dat;

  assign in_rdy  = ~vld | (out_rdy & pass_en);
  assign out_msg = dat;
  assign out_val = vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (in_val && in_rdy) begin
      vld <= 1'b1;
      dat <= in_msg;
    end else if (vld && out_rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/rva_router_n.sv
// RVA request/response router to NUM_CH channels plus start broadcast / done gather.
// Optional RVA_ERR_RSP_EN: out-of-range reads return an all-ones response.
module rva_router_n
  import rva_router_n_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int MSG_W   = DEF_MSG_W,
  parameter int RSP_W   = DEF_RSP_W,
  parameter int SEL_LSB = DEF_SEL_LSB,
  parameter int SEL_MSB = DEF_SEL_MSB
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MSG_W-1:0]              rva_in_msg,
  input  logic                          rva_in_val,
  output logic                          rva_in_rdy,
  output logic [RSP_W-1:0]              rva_out_msg,
  output logic                          rva_out_val,
  input  logic                          rva_out_rdy,
  output logic [NUM_CH-1:0][MSG_W-1:0]  ch_rva_in_msg,
  output logic [NUM_CH-1:0]             ch_rva_in_val,
  input  logic [NUM_CH-1:0]             ch_rva_in_rdy,
  input  logic [NUM_CH-1:0][RSP_W-1:0]  ch_rva_out_msg,
  input  logic [NUM_CH-1:0]             ch_rva_out_val,
  output logic [NUM_CH-1:0]             ch_rva_out_rdy,
  input  logic                          start_msg,
  input  logic                          start_val,
  output logic                          start_rdy,
  output logic                          ch_start_msg,
  output logic [NUM_CH-1:0]             ch_start_val,
  input  logic [NUM_CH-1:0]             ch_start_rdy,
  input  logic [NUM_CH-1:0]             ch_done_val,
  output logic [NUM_CH-1:0]             ch_done_rdy,
  output logic                          done_msg,
  output logic                          done_val,
  input  logic                          done_rdy
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;

  // ---------------- request path ----------------
  logic [MSG_W-1:0]  req_msg;
  logic              req_vld;
  logic              req_drain;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] sel_oh;
  logic              in_range;
  logic              is_rd;
  logic              issue_ok;
  logic              oor_drain;
  logic              err_push;
  logic              rd_issue;
  logic              os_vld;
  logic [NUM_CH-1:0] os_mask;

  rva_router_n_skid #(.W(MSG_W)) u_req_skid (
    .clk     (clk),
    .rst     (rst),
    .in_msg  (rva_in_msg),
    .in_val  (rva_in_val),
    .in_rdy  (rva_in_rdy),
    .out_msg (req_msg),
    .out_val (req_vld),
    .out_rdy (req_drain),
    .pass_en (~os_vld)
  );

  assign sel   = req_msg[SEL_MSB:SEL_LSB];
  assign is_rd = ~req_msg[MSG_W-1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sel
    assign sel_oh[i]        = (int'(sel) == i);
    assign ch_rva_in_msg[i] = req_msg;
  end

  assign in_range      = |sel_oh;
  assign issue_ok      = ~is_rd | ~os_vld;
  assign ch_rva_in_val = sel_oh & {NUM_CH{req_vld & issue_ok}};

`ifdef RVA_ERR_RSP_EN
  // An out-of-range read takes the outstanding slot like a real read so its
  // error response cannot collide with a channel response.
  assign oor_drain = issue_ok;
  assign err_push  = req_vld & ~in_range & is_rd & ~os_vld;
`else
  assign oor_drain = 1'b1;
  assign err_push  = 1'b0;
`endif

  assign req_drain = in_range ? (issue_ok & |(sel_oh & ch_rva_in_rdy)) : oor_drain;
  assign rd_issue  = req_vld & is_rd & (|(ch_rva_in_val & ch_rva_in_rdy) | err_push);

  // ---------------- response path ----------------
  logic [RSP_W-1:0] rsp_in_msg;
  logic             rsp_in_val;
  logic             rsp_in_rdy;

  // No refill while draining, so the owner can never land a second response.
  rva_router_n_skid #(.W(RSP_W)) u_rsp_skid (
    .clk     (clk),
    .rst     (rst),
    .in_msg  (rsp_in_msg),
    .in_val  (rsp_in_val),
    .in_rdy  (rsp_in_rdy),
    .out_msg (rva_out_msg),
    .out_val (rva_out_val),
    .out_rdy (rva_out_rdy),
    .pass_en (1'b0)
  );

  assign ch_rva_out_rdy = os_mask & {NUM_CH{rsp_in_rdy}};
  assign rsp_in_val     = |(ch_rva_out_val & ch_rva_out_rdy) | err_push;

  always_comb begin
    rsp_in_msg = err_push ? {RSP_W{ERR_RSP_BIT}} : '0;
    for (int i = 0; i < NUM_CH; i++)
      if (os_mask[i]) rsp_in_msg = rsp_in_msg | ch_rva_out_msg[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      os_vld  <= 1'b0;
      os_mask <= '0;
    end else if (rd_issue) begin
      os_vld  <= 1'b1;
      os_mask <= sel_oh;
    end else if (rva_out_val && rva_out_rdy) begin
      os_vld  <= 1'b0;
      os_mask <= '0;
    end
  end

  // ---------------- start / done FSM ----------------
  start_st_e         st;
  logic              start_lat;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] done_mask;
  logic [NUM_CH-1:0] pend_n;
  logic [NUM_CH-1:0] done_n;

  assign pend_n       = pend & ~ch_start_rdy;
  assign done_n       = done_mask | (ch_done_val & ch_done_rdy);
  assign ch_start_val = pend;
  assign ch_start_msg = start_lat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= ST_IDLE;
      start_lat   <= 1'b0;
      pend        <= '0;
      done_mask   <= '0;
      start_rdy   <= 1'b1;
      ch_done_rdy <= '0;
      done_val    <= 1'b0;
      done_msg    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (start_val) begin
          st        <= ST_BCAST;
          start_lat <= start_msg;
          pend      <= '1;
          start_rdy <= 1'b0;
        end
        ST_BCAST: begin
          pend <= pend_n;
          if (pend_n == '0) begin
            st          <= ST_RUN;
            ch_done_rdy <= '1;
          end
        end
        ST_RUN: begin
          done_mask   <= done_n;
          ch_done_rdy <= ~done_n;
          if (&done_n) begin
            st       <= ST_DONE;
            done_val <= 1'b1;
            done_msg <= 1'b1;
          end
        end
        ST_DONE: if (done_rdy) begin
          st        <= ST_IDLE;
          done_val  <= 1'b0;
          done_msg  <= 1'b0;
          done_mask <= '0;
          start_lat <= 1'b0;
          start_rdy <= 1'b1;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rva_router_n.sv
// Directed bench for rva_router_n with NUM_CH=4: routing, read ordering, start/done, reset.
module tb_rva_router_n;

  localparam int NCH   = 4;
  localparam int MSG_W = 169;
  localparam int RSP_W = 128;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [MSG_W-1:0]            rva_in_msg;
  logic                        rva_in_val;
  logic                        rva_in_rdy;
  logic [RSP_W-1:0]            rva_out_msg;
  logic                        rva_out_val;
  logic                        rva_out_rdy;
  logic [NCH-1:0][MSG_W-1:0]   ch_rva_in_msg;
  logic [NCH-1:0]              ch_rva_in_val;
  logic [NCH-1:0]              ch_rva_in_rdy;
  logic [NCH-1:0][RSP_W-1:0]   ch_rva_out_msg;
  logic [NCH-1:0]              ch_rva_out_val;
  logic [NCH-1:0]              ch_rva_out_rdy;
  logic                        start_msg, start_val, start_rdy;
  logic                        ch_start_msg;
  logic [NCH-1:0]              ch_start_val, ch_start_rdy;
  logic [NCH-1:0]              ch_done_val, ch_done_rdy;
  logic                        done_msg, done_val, done_rdy;

  int n_chk = 0;
  int n_err = 0;

  rva_router_n #(.NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst),
    .rva_in_msg(rva_in_msg), .rva_in_val(rva_in_val), .rva_in_rdy(rva_in_rdy),
    .rva_out_msg(rva_out_msg), .rva_out_val(rva_out_val), .rva_out_rdy(rva_out_rdy),
    .ch_rva_in_msg(ch_rva_in_msg), .ch_rva_in_val(ch_rva_in_val), .ch_rva_in_rdy(ch_rva_in_rdy),
    .ch_rva_out_msg(ch_rva_out_msg), .ch_rva_out_val(ch_rva_out_val), .ch_rva_out_rdy(ch_rva_out_rdy),
    .start_msg(start_msg), .start_val(start_val), .start_rdy(start_rdy),
    .ch_start_msg(ch_start_msg), .ch_start_val(ch_start_val), .ch_start_rdy(ch_start_rdy),
    .ch_done_val(ch_done_val), .ch_done_rdy(ch_done_rdy),
    .done_msg(done_msg), .done_val(done_val), .done_rdy(done_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MSG_W-1:0] mk_req(input logic wr, input logic [3:0] s, input logic [15:0] tag);
    logic [MSG_W-1:0] r;
    r = '0;
    r[MSG_W-1] = wr;
    r[23:20]   = s;
    r[15:0]    = tag;
    return r;
  endfunction

  // Send one request: present it, take the accepting edge, deassert.
  task automatic send(input logic [MSG_W-1:0] m);
    rva_in_msg = m;
    rva_in_val = 1'b1;
    tick();
    rva_in_val = 1'b0;
  endtask

  logic [MSG_W-1:0] ra, rb;

  initial begin
    rst = 1'b0;
    rva_in_msg = '0; rva_in_val = 1'b0; rva_out_rdy = 1'b0;
    ch_rva_in_rdy = '1; ch_rva_out_msg = '0; ch_rva_out_val = '0;
    start_msg = 1'b0; start_val = 1'b0; ch_start_rdy = '0;
    ch_done_val = '0; done_rdy = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_in_rdy",     rva_in_rdy, 1);
    chk("rst_start_rdy",  start_rdy, 1);
    chk("rst_out_val",    rva_out_val, 0);
    chk("rst_out_msg",    rva_out_msg, 0);
    chk("rst_ch_in_val",  ch_rva_in_val, 0);
    chk("rst_ch_st_val",  ch_start_val, 0);
    chk("rst_done_val",   done_val, 0);

    // write routed to channel 2, no response expected
    ra = mk_req(1'b1, 4'd2, 16'h1234);
    send(ra);
    chk("wr_ch_val",  ch_rva_in_val, 4'b0100);
    chk("wr_ch_msg",  ch_rva_in_msg[2], ra);
    tick();
    chk("wr_drained", ch_rva_in_val, 0);
    chk("wr_no_rsp",  rva_out_val, 0);
    chk("wr_no_os",   ch_rva_out_rdy, 0);

    // read ch1 then read ch3 back to back: ch3 must wait for ch1's response
    ra = mk_req(1'b0, 4'd1, 16'h00a1);
    rb = mk_req(1'b0, 4'd3, 16'h00b3);
    send(ra);
    rva_in_msg = rb;
    rva_in_val = 1'b1;
    #1;
    chk("rd1_ch_val",   ch_rva_in_val, 4'b0010);
    chk("rd1_in_rdy",   rva_in_rdy, 1);
    tick();
    rva_in_val = 1'b0;
    chk("rd3_stalled",  ch_rva_in_val, 0);
    chk("rd1_owner",    ch_rva_out_rdy, 4'b0010);
    chk("rd_in_full",   rva_in_rdy, 0);

    // unsolicited ch0 response is stalled
    ch_rva_out_val = 4'b0001;
    ch_rva_out_msg[0] = 128'hdead;
    tick(); tick();
    chk("unsol_rdy",    ch_rva_out_rdy, 4'b0010);
    chk("unsol_no_fwd", rva_out_val, 0);

    ch_rva_out_val = 4'b0011;
    ch_rva_out_msg[1] = 128'h5151;
    tick();
    ch_rva_out_val = 4'b0001;
    #1;
    chk("rsp1_val",     rva_out_val, 1);
    chk("rsp1_msg",     rva_out_msg, 128'h5151);
    chk("rsp1_full",    ch_rva_out_rdy, 0);
    chk("rd3_still",    ch_rva_in_val, 0);
    rva_out_rdy = 1'b1;
    tick();
    rva_out_rdy = 1'b0;
    #1;
    chk("rsp1_gone",    rva_out_val, 0);
    chk("rd3_issue",    ch_rva_in_val, 4'b1000);
    chk("rd3_msg",      ch_rva_in_msg[3], rb);
    tick();
    chk("rd3_owner",    ch_rva_out_rdy, 4'b1000);
    ch_rva_out_val = 4'b1001;
    ch_rva_out_msg[3] = 128'h3333;
    tick();
    ch_rva_out_val = 4'b0000;
    #1;
    chk("rsp3_msg",     rva_out_msg, 128'h3333);
    rva_out_rdy = 1'b1;
    tick();
    rva_out_rdy = 1'b0;
    #1;
    chk("rsp3_gone",    rva_out_val, 0);

    // out-of-range read (sel=7)
    send(mk_req(1'b0, 4'd7, 16'h0077));
    #1;
    chk("oor_ch_val",   ch_rva_in_val, 0);
    chk("oor_in_rdy",   rva_in_rdy, 1);
    tick();
`ifdef RVA_ERR_RSP_EN
    chk("oor_err_val",  rva_out_val, 1);
    chk("oor_err_msg",  rva_out_msg, {RSP_W{1'b1}});
    rva_out_rdy = 1'b1;
    tick();
    rva_out_rdy = 1'b0;
    #1;
    chk("oor_err_gone", rva_out_val, 0);
`else
    chk("oor_no_rsp",   rva_out_val, 0);
    chk("oor_in_rdy2",  rva_in_rdy, 1);
`endif

    // start broadcast with ch2 late, then done in order 3,0,1,2
    start_msg = 1'b1;
    start_val = 1'b1;
    #1;
    chk("st_idle_rdy",  start_rdy, 1);
    tick();
    start_val = 1'b0;
    chk("st_bcast_val", ch_start_val, 4'b1111);
    chk("st_bcast_msg", ch_start_msg, 1);
    chk("st_rdy_low0",  start_rdy, 0);
    ch_start_rdy = 4'b1011;
    tick();
    chk("st_pend_ch2",  ch_start_val, 4'b0100);
    tick(); tick();
    chk("st_pend_hold", ch_start_val, 4'b0100);
    chk("st_rdy_low1",  start_rdy, 0);
    ch_start_rdy = 4'b1111;
    tick();
    ch_start_rdy = 4'b0000;
    chk("st_run_val",   ch_start_val, 0);
    chk("run_done_rdy", ch_done_rdy, 4'b1111);
    ch_done_val = 4'b1000; tick();
    chk("done_rdy_3",   ch_done_rdy, 4'b0111);
    ch_done_val = 4'b0001; tick();
    chk("done_rdy_0",   ch_done_rdy, 4'b0110);
    ch_done_val = 4'b0010; tick();
    chk("done_rdy_1",   ch_done_rdy, 4'b0100);
    chk("done_early",   done_val, 0);
    chk("st_rdy_low2",  start_rdy, 0);
    ch_done_val = 4'b0100; tick();
    ch_done_val = 4'b0000;
    chk("done_val",     done_val, 1);
    chk("done_msg",     done_msg, 1);
    chk("done_rdy_off", ch_done_rdy, 0);
    chk("st_rdy_low3",  start_rdy, 0);
    done_rdy = 1'b1;
    tick();
    done_rdy = 1'b0;
    chk("done_cleared", done_val, 0);
    chk("st_back_idle", start_rdy, 1);

    // reset in RUN with a read outstanding
    start_val = 1'b1; tick(); start_val = 1'b0;
    ch_start_rdy = 4'b1111; tick(); ch_start_rdy = 4'b0000;
    send(mk_req(1'b0, 4'd1, 16'h0c01));
    tick();
    chk("pre_rst_os",   ch_rva_out_rdy, 4'b0010);
    chk("pre_rst_run",  ch_done_rdy, 4'b1111);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_os",     ch_rva_out_rdy, 0);
    chk("mid_rst_st_rdy", start_rdy, 1);
    chk("mid_rst_dn_rdy", ch_done_rdy, 0);
    chk("mid_rst_st_val", ch_start_val, 0);
    chk("mid_rst_in_rdy", rva_in_rdy, 1);
    chk("mid_rst_in_val", ch_rva_in_val, 0);
    ra = mk_req(1'b0, 4'd1, 16'h0c02);
    send(ra);
    chk("post_rst_issue", ch_rva_in_val, 4'b0010);
    tick();
    chk("post_rst_os",    ch_rva_out_rdy, 4'b0010);
    ch_rva_out_val = 4'b0010;
    ch_rva_out_msg[1] = 128'h0c0c;
    tick();
    ch_rva_out_val = 4'b0000;
    chk("post_rst_rsp",   rva_out_msg, 128'h0c0c);
    chk("post_rst_val",   rva_out_val, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rva_router_n.md
RVA_ROUTER_N -- requirements
Module: rva_router_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, giving the number of downstream channels (legal 2..8).
REQ-002 SHALL have parameter MSG_W, default 169, giving the RVA request width; bit MSG_W-1 is the write flag.
REQ-003 SHALL have parameter RSP_W, default 128, giving the RVA response width.
REQ-004 SHALL have parameters SEL_LSB and SEL_MSB, defaults 20 and 23, giving the request field that selects the channel.
REQ-005 SHALL have one clock and a synchronous active-low reset: clk and rst.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, sync active-low reset
- rva_in_msg/val/rdy, in/in/out, MSG_W/1/1, upstream request
- rva_out_msg/val/rdy, out/out/in, RSP_W/1/1, upstream response
- ch_rva_in_msg/val/rdy, out/out/in, NUM_CH*MSG_W/NUM_CH/NUM_CH, per-channel request
- ch_rva_out_msg/val/rdy, in/in/out, NUM_CH*RSP_W/NUM_CH/NUM_CH, per-channel response
- start_msg/val/rdy, in/in/out, 1/1/1, upstream start
- ch_start_msg/val/rdy, out/out/in, 1/NUM_CH/NUM_CH, broadcast start
- ch_done_val/rdy, in/out, NUM_CH/NUM_CH, per-channel done
- done_msg/val/rdy, out/out/in, 1/1/1, aggregate done

Function
REQ-007 Transfer SHALL occur only on a cycle with val&rdy both high; val, once high, SHALL hold with stable msg until the transfer.
REQ-008 The request path SHALL be a 1-entry buffer: rva_in_rdy = buffer empty, or buffer draining this cycle and no read outstanding.
REQ-009 A request accepted in cycle N SHALL present ch_rva_in_val[sel] in cycle N+1, where sel = msg[SEL_MSB:SEL_LSB]; other channel val bits stay low.
REQ-010 At most one read SHALL be outstanding; a buffered read SHALL not issue while a read is outstanding; writes are not tracked.
REQ-011 Only the channel owning the outstanding read SHALL see ch_rva_out_rdy high; unsolicited responses from other channels SHALL be stalled.
REQ-012 The response SHALL be registered: a channel response accepted in cycle N SHALL give rva_out_val in N+1; outstanding clears on the upstream transfer.
REQ-013 A request with sel >= NUM_CH SHALL be consumed in one cycle without asserting any ch_rva_in_val.
REQ-014 The start FSM SHALL have states IDLE, BCAST, RUN, DONE; start_rdy SHALL be high only in IDLE.
REQ-015 IDLE->BCAST on start transfer: latch start_msg and set the pending mask to all ones; ch_start_val = pending; ch_start_msg = latched msg.
REQ-016 BCAST: each ch_start transfer SHALL clear its pending bit; the FSM SHALL go to RUN when the mask reaches zero; acceptance in the same cycle counts.
REQ-017 RUN: ch_done_rdy SHALL be high for channels not yet done; the FSM SHALL go to DONE once all done bits are set, including bits set that cycle.
REQ-018 DONE: done_val=1, done_msg=1; the FSM SHALL go to IDLE on the done transfer and clear the done mask.
REQ-019 The RVA path and the start/done path SHALL operate concurrently and independently.

Reset
REQ-020 On rst=0 at a clk edge, all of the following SHALL hold in the next cycle, and reset mid-transaction SHALL discard all state:
- buffer empty, outstanding cleared, FSM in IDLE
- masks cleared
- all val outputs 0, msg outputs 0
- rva_in_rdy=1 and start_rdy=1

Configuration
REQ-021 With RVA_ERR_RSP_EN defined, an out-of-range read SHALL produce rva_out_msg all-ones with rva_out_val one cycle after acceptance; an out-of-range write SHALL still be dropped.
REQ-022 Without RVA_ERR_RSP_EN, all out-of-range requests SHALL be silently dropped.

Structure
REQ-023 The shared package SHALL hold the default widths, the select-field constants, the FSM state enum, and the error-response constant.
REQ-024 The design SHALL have one sub-module, rva_router_n_skid, a parametrised 1-entry val/rdy buffer used for the request and response paths.

Verification
REQ-025 NUM_CH=4: write with sel=2 -> ch_rva_in_val=4'b0100 one cycle later; no response.
REQ-026 Read to ch1, then read to ch3 presented immediately -> the ch3 request SHALL stall until ch1's response transfers upstream.
REQ-027 Ch0 asserts an unsolicited response while ch1 owns the read -> ch_rva_out_rdy=4'b0010; the ch0 response is not forwarded.
REQ-028 Start with ch_start_rdy staggered (ch2 late by 3 cycles), then done in order 3,0,1,2 -> done_val one cycle after the last done transfer; start_rdy low throughout.
REQ-029 Read with sel=7, NUM_CH=4 -> with RVA_ERR_RSP_EN, rva_out_msg all-ones; without it, no rva_out_val and rva_in_rdy high next cycle.
REQ-030 Assert rst=0 in RUN with a read outstanding -> next cycle the IDLE reset values hold, and a new read issues normally.
